instruction_memory: RTL and testbench
=====================================

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 16: instruction word width in bits.
REQ-002 Parameter PC_WIDTH, default 16: program-counter width in bits.
REQ-003 Parameter DEPTH_LOG2, default 8: log2 of ROM depth in words (256 words).
REQ-004 The port clk SHALL be: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-005 The port rst SHALL be: input, 1 bit, reset; asynchronous and active-low.
REQ-006 The port programcounter SHALL be: input, PC_WIDTH bits, byte address of the instruction to fetch.
REQ-007 The port outRegister SHALL be: output, DATA_WIDTH bits, registered fetched instruction.

Function
REQ-008 Memory SHALL be a read-only, byte-addressed store of 16-bit words; word index = programcounter[DEPTH_LOG2:1].
REQ-009 programcounter[0] SHALL be ignored; an odd address returns the word at the even address below it.
REQ-010 If any bit of programcounter[PC_WIDTH-1:DEPTH_LOG2+1] is 1 (out of range), the fetched word SHALL be 0x0000 (NOP).
REQ-011 On each rising clk edge with rst=1, outRegister SHALL load the word addressed by the programcounter value sampled at that edge; latency is exactly one clock.
REQ-012 Between rising edges outRegister SHALL hold its value regardless of programcounter changes.
REQ-013 The ROM image SHALL be: word0 0x0000, word1 0x1101, word2 0x2202, word3 0x3303, word4 0x4404, word5 0x5505, word6 0x6606, word7 0x7707; words 8..255 are 0x0000.
REQ-014 An unknown/X programcounter SHALL NOT corrupt stored contents; the ROM has no write path.
REQ-015 Repeated fetches of the same address on consecutive edges SHALL return the same word every cycle.

Reset
REQ-016 While rst=0, outRegister SHALL be 0x0000, asserted immediately (asynchronously), independent of clk.
REQ-017 Reset asserted mid-operation SHALL clear outRegister at once; ROM contents are unaffected.
REQ-018 After rst rises, the first rising clk edge with rst=1 SHALL perform a normal fetch; an edge coincident with rst rising is treated as still in reset.

Structure
REQ-019 A shared package instruction_memory_pkg SHALL hold DATA_WIDTH, PC_WIDTH, DEPTH_LOG2 defaults, the NOP constant 0x0000, and the ROM image table.
REQ-020 One sub-module, instruction_rom, SHALL implement the combinational word-index-to-data lookup, including the out-of-range NOP rule; instruction_memory adds address decode and the output register.

Verification
REQ-021 rst=0 at t=0, clk toggling, programcounter undriven -> outRegister=0x0000 throughout reset.
REQ-022 rst released, programcounter=0x0002 -> outRegister=0x1101 after the next rising edge; with programcounter 0x0004 then 0x0006, outRegister=0x2202 then 0x3303, one edge after each change.
REQ-023 programcounter=0x0005 -> outRegister=0x2202 (bit 0 ignored); programcounter=0x000E -> outRegister=0x7707.
REQ-024 programcounter=0x0200 and 0xFFFE -> outRegister=0x0000; programcounter=0x01FE -> outRegister=0x0000 (word 255).
REQ-025 With outRegister=0x3303, drive rst=0 between clk edges -> outRegister=0x0000 immediately; release rst -> correct word after the first subsequent rising edge.
REQ-026 Change programcounter from 0x0002 to 0x0004 between edges -> outRegister holds 0x1101 until the next rising edge, then shows 0x2202.

Source files
------------

// File: rtl/instruction_memory_pkg.sv
// Shared sizing defaults, the NOP encoding and the boot ROM image for the
// instruction fetch path.
package instruction_memory_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned PC_WIDTH_DEF   = 16;
  localparam int unsigned DEPTH_LOG2_DEF = 8;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned IMAGE_WORDS = 8;
  localparam int unsigned IMAGE_IDX_W = 3;

  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  // Populated words; every index beyond the table reads as NOP.
  localparam logic [WORD_W-1:0] ROM_IMAGE [IMAGE_WORDS] = '{
    16'h0000, 16'h1101, 16'h2202, 16'h3303,
    16'h4404, 16'h5505, 16'h6606, 16'h7707
  };

  function automatic logic [WORD_W-1:0] rom_word(input int unsigned idx);
    rom_word = NOP_WORD;
    if (idx < IMAGE_WORDS) rom_word = ROM_IMAGE[idx[IMAGE_IDX_W-1:0]];
  endfunction

endpackage

// File: rtl/instruction_memory_rom.sv
// Combinational word-index to instruction lookup; out-of-range fetches read NOP.
module instruction_rom
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic [DEPTH_LOG2-1:0] word_index,
  input  logic                  out_of_range,
  output logic [DATA_WIDTH-1:0] data_c
);

  always_comb begin
    data_c = DATA_WIDTH'(NOP_WORD);
    if (!out_of_range) data_c = DATA_WIDTH'(rom_word(32'(word_index)));
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction fetch: byte address decode into the ROM plus a one-cycle output
// register that clears asynchronously while rst is low.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   programcounter,
  output logic [DATA_WIDTH-1:0] outRegister
);

  logic [DEPTH_LOG2-1:0] word_index;
  logic                  out_of_range;
  logic [DATA_WIDTH-1:0] fetch_data_c;
  logic                  unused_byte_sel;

  // Byte addressing of 16-bit words: bit 0 selects nothing.
  assign word_index      = programcounter[DEPTH_LOG2:1];
  assign unused_byte_sel = programcounter[0];

  if (PC_WIDTH > DEPTH_LOG2 + 1) begin : g_range_chk
    assign out_of_range = |programcounter[PC_WIDTH-1:DEPTH_LOG2+1];
  end else begin : g_no_range_chk
    assign out_of_range = 1'b0;
  end

  instruction_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rom (
    .word_index   (word_index),
    .out_of_range (out_of_range),
    .data_c       (fetch_data_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) outRegister <= DATA_WIDTH'(NOP_WORD);
    else      outRegister <= fetch_data_c;
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed boundary cases, reset
// behaviour and random fetches against an arithmetic model of the ROM image.
module tb_instruction_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] programcounter;
  logic [15:0] outRegister;

  int unsigned errors = 0;
  int unsigned checks = 0;

  instruction_memory dut (
    .clk            (clk),
    .rst            (rst),
    .programcounter (programcounter),
    .outRegister    (outRegister)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: word k of the image is k in nibbles 3, 2 and 0 for k < 8.
  function automatic logic [15:0] ref_word(input logic [15:0] pc);
    int unsigned idx;
    if (pc >= 16'h0200) return 16'h0000;
    idx = int'(pc) / 2;
    if (idx >= 8) return 16'h0000;
    return 16'((idx << 12) + (idx << 8) + idx);
  endfunction

  // Advance to the next rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] pc, input logic [15:0] exp);
    programcounter = pc;
    tick();
    check_eq(tag, outRegister, exp);
  endtask

  initial begin
    logic [15:0] pc;
    rst = 1'b0;

    // Held in reset with an undriven address.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("reset_hold", outRegister, 16'h0000);
    end

    @(negedge clk);
    rst = 1'b1;
    programcounter = 16'h0002;
    tick();
    check_eq("first_fetch", outRegister, 16'h1101);
    fetch("pc_0004", 16'h0004, 16'h2202);
    fetch("pc_0006", 16'h0006, 16'h3303);

    // Asynchronous reset between edges.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("async_reset", outRegister, 16'h0000);
    @(posedge clk);
    #1;
    check_eq("reset_across_edge", outRegister, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("release_no_edge", outRegister, 16'h0000);
    tick();
    check_eq("post_reset_fetch", outRegister, 16'h3303);

    // Directed odd-address and range boundaries.
    fetch("pc_0005", 16'h0005, 16'h2202);
    fetch("pc_000E", 16'h000E, 16'h7707);
    fetch("pc_000F", 16'h000F, 16'h7707);
    fetch("pc_0010", 16'h0010, 16'h0000);
    fetch("pc_0200", 16'h0200, 16'h0000);
    fetch("pc_FFFE", 16'hFFFE, 16'h0000);
    fetch("pc_01FE", 16'h01FE, 16'h0000);
    fetch("pc_0202", 16'h0202, 16'h0000);

    // Hold between edges while the address changes.
    fetch("pc_0002", 16'h0002, 16'h1101);
    #3;
    programcounter = 16'h0004;
    #2;
    check_eq("hold_between_edges", outRegister, 16'h1101);
    tick();
    check_eq("after_change", outRegister, 16'h2202);

    // Same address on consecutive edges.
    for (int i = 0; i < 3; i++) fetch("repeat_0008", 16'h0008, 16'h4404);

    // Random fetches, biased toward populated words and the range boundary.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       pc = 16'($urandom_range(0, 31));
        1:       pc = 16'($urandom_range(16'h01F0, 16'h020F));
        default: pc = 16'($urandom);
      endcase
      fetch("random", pc, ref_word(pc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
